// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the FIR engine and its result streamer.
package fir_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Default region the FIR engine writes its results into.
  localparam logic [ADDR_W-1:0] OUT_BASE = 10'd256;

endpackage

// File: rtl/stream_fifo.sv
// Small synchronous FIFO whose head entry is always a register, so the
// output stream data comes straight from a flop.
module stream_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             din,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic             push_ok;
  logic             pop_ok;
  logic [CNT_W-1:0] wr_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign wr_idx  = pop_ok ? (count_q - 1'b1) : count_q;
  assign head    = mem_q[0];
  assign count   = count_q;

  // Entries shift toward slot 0 on pop; the incoming word lands just behind
  // the last valid entry after any shift in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH-1; i++) begin
          mem_q[i] <= mem_q[i+1];
        end
      end
      if (push_ok) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            mem_q[i] <= din;
          end
        end
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fir_result_streamer.sv
// Reads a finished FIR output region over memory port B and streams it out
// as a valid/ready byte stream with a last marker on the final beat.
module fir_result_streamer #(
  parameter int ADDR_W     = fir_pkg::ADDR_W,
  parameter int DATA_W     = fir_pkg::DATA_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic              busy,
  output logic              done,
  output logic              mem_en_b,
  output logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_data_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last
);

  import fir_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH+1);

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   issued_q;
  logic [ADDR_W:0]   beats_q;
  logic              inflight_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W:0]    level;
  logic              pop;
  logic              issue;

  assign m_valid = !fifo_empty;
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (beats_q == (count_q - 1'b1));

  // Occupancy plus the read still in flight must stay within the FIFO; a pop
  // in the same cycle frees the slot the new read will need.
  assign level = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign issue = (state_q == ST_READ) && (issued_q != count_q) &&
                 (pop || (!fifo_full && (level < (CNT_W+1)'(FIFO_DEPTH))));

  assign mem_en_b   = issue;
  assign mem_addr_b = base_q + issued_q[ADDR_W-1:0];
  assign busy       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_FINISH);

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .pop   (pop),
    .din   (mem_data_b),
    .head  (m_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Clearing inflight_q on reset drops any read data that returns afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      count_q    <= '0;
      issued_q   <= '0;
      beats_q    <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        issued_q <= issued_q + 1'b1;
      end
      if (pop) begin
        beats_q <= beats_q + 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            base_q   <= base_addr;
            count_q  <= {1'b0, count};
            issued_q <= '0;
            beats_q  <= '0;
            state_q  <= (count == '0) ? ST_FINISH : ST_READ;
          end
        end
        ST_READ: begin
          if (issue && ((issued_q + 1'b1) == count_q)) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state_q <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_result_streamer.sv
// Directed bench for fir_result_streamer: basic, backpressure, wrap, zero
// count, ignored restart and mid-transfer reset.
module tb_fir_result_streamer;

  import fir_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] base_addr;
  logic [9:0] count;
  logic       busy;
  logic       done;
  logic       mem_en_b;
  logic [9:0] mem_addr_b;
  logic [7:0] mem_data_b = 8'h00;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  logic [7:0] mem [1024];

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] beat_data[$];
  logic       beat_last[$];
  int         beat_cyc[$];
  logic [9:0] addr_q[$];
  int done_cnt, done_cyc, first_valid, stall_errs, max_out, busy_cycles, valid_cycles;

  fir_result_streamer #(
    .ADDR_W     (10),
    .DATA_W     (8),
    .FIFO_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .mem_en_b   (mem_en_b),
    .mem_addr_b (mem_addr_b),
    .mem_data_b (mem_data_b),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read port B model: data appears the cycle after the enable.
  always @(posedge clk) begin
    if (mem_en_b) mem_data_b <= mem[mem_addr_b];
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] b, input logic [9:0] n);
    @(negedge clk);
    base_addr = b;
    count     = n;
    start     = 1'b1;
  endtask

  // Runs cycles after a start edge, recording beats, read addresses and flags.
  task automatic collectBeats(input int ready_mode, input int restart_cyc,
                              input int stop_beats, input int max_cyc);
    logic       prev_stall;
    logic [7:0] prev_data;
    logic       prev_last;
    int         issue_n;
    beat_data.delete(); beat_last.delete(); beat_cyc.delete(); addr_q.delete();
    done_cnt = 0; done_cyc = -1; first_valid = -1; stall_errs = 0;
    max_out = 0; busy_cycles = 0; valid_cycles = 0; issue_n = 0;
    prev_stall = 1'b0; prev_data = 8'h00; prev_last = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      @(negedge clk);
      start = (c == restart_cyc);
      if (c == restart_cyc) begin
        base_addr = 10'd1020;
        count     = 10'd7;
      end
      m_ready = (ready_mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
      #1;
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_errs++;
      if (m_valid && first_valid < 0) first_valid = c;
      if (m_valid) valid_cycles++;
      if (busy) busy_cycles++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (mem_en_b) begin
        addr_q.push_back(mem_addr_b);
        issue_n++;
      end
      if (m_valid && m_ready) begin
        beat_data.push_back(m_data);
        beat_last.push_back(m_last);
        beat_cyc.push_back(c);
      end
      if (issue_n - beat_data.size() > max_out) max_out = issue_n - beat_data.size();
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (stop_beats > 0 && beat_data.size() == stop_beats) break;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic checkBeats(input string tag, input int n);
    int lim;
    checkOutput({tag, "_beat_count"}, beat_data.size(), n);
    lim = (beat_data.size() < n) ? beat_data.size() : n;
    for (int i = 0; i < lim; i++) begin
      checkOutput($sformatf("%s_data%0d", tag, i), beat_data[i], exp_q[i]);
      checkOutput($sformatf("%s_last%0d", tag, i), beat_last[i], (i == n-1));
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_mem_en_b"}, mem_en_b, 1'b0);
    checkOutput({tag, "_mem_addr_b"}, mem_addr_b, 10'd0);
    checkOutput({tag, "_m_valid"}, m_valid, 1'b0);
    checkOutput({tag, "_m_data"}, m_data, 8'h00);
    checkOutput({tag, "_m_last"}, m_last, 1'b0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; m_ready = 1'b0; base_addr = '0; count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 8'h55;
    for (int i = 0; i < 20; i++) mem[256+i] = 8'(i);
    mem[1020] = 8'hFC; mem[1021] = 8'hFD; mem[1022] = 8'hFE; mem[1023] = 8'hFF;
    mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04;
    repeat (2) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] basic transfer");
    exp_q.delete();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'(i));
    applyStimulus(OUT_BASE, 10'd20);
    collectBeats(0, -1, 0, 200);
    checkBeats("basic", 20);
    checkOutput("basic_first_valid", first_valid, 2);
    if (beat_cyc.size() == 20) checkOutput("basic_consecutive", beat_cyc[19] - beat_cyc[0], 19);
    if (beat_cyc.size() == 20) checkOutput("basic_done_cycle", done_cyc, beat_cyc[19] + 1);
    checkOutput("basic_done_count", done_cnt, 1);
    checkOutput("basic_reads", addr_q.size(), 20);
    checkOutput("basic_busy_after", busy, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(OUT_BASE, 10'd20);
    collectBeats(1, -1, 0, 400);
    checkBeats("bp", 20);
    checkOutput("bp_stall_stable", stall_errs, 0);
    checkOutput("bp_outstanding_le2", (max_out <= 2), 1'b1);
    checkOutput("bp_reads", addr_q.size(), 20);
    checkOutput("bp_done_count", done_cnt, 1);

    $display("[TB] wrap-around");
    exp_q = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04};
    applyStimulus(10'd1020, 10'd8);
    collectBeats(0, -1, 0, 100);
    checkBeats("wrap", 8);
    checkOutput("wrap_reads", addr_q.size(), 8);
    if (addr_q.size() == 8) begin
      checkOutput("wrap_addr0", addr_q[0], 10'd1020);
      checkOutput("wrap_addr3", addr_q[3], 10'd1023);
      checkOutput("wrap_addr4", addr_q[4], 10'd0);
      checkOutput("wrap_addr7", addr_q[7], 10'd3);
    end
    checkOutput("wrap_done_count", done_cnt, 1);

    $display("[TB] zero count");
    applyStimulus(OUT_BASE, 10'd0);
    collectBeats(0, -1, 0, 20);
    checkOutput("zero_reads", addr_q.size(), 0);
    checkOutput("zero_valid", valid_cycles, 0);
    checkOutput("zero_done_count", done_cnt, 1);
    checkOutput("zero_busy_le1", (busy_cycles <= 1), 1'b1);

    $display("[TB] ignored start and mid-transfer reset");
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(8'(i));
    applyStimulus(OUT_BASE, 10'd20);
    collectBeats(0, 3, 5, 100);
    checkOutput("restart_beat_count", beat_data.size(), 5);
    for (int i = 0; i < beat_data.size(); i++)
      checkOutput($sformatf("restart_data%0d", i), beat_data[i], exp_q[i]);
    checkOutput("restart_busy", busy, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(negedge clk);
    rst = 1'b1;
    collectBeats(0, -1, 0, 4);
    checkOutput("midreset_no_stale", valid_cycles, 0);
    checkOutput("midreset_no_done", done_cnt, 0);

    exp_q = '{8'h00, 8'h01, 8'h02};
    applyStimulus(OUT_BASE, 10'd3);
    collectBeats(0, -1, 0, 50);
    checkBeats("after_reset", 3);
    checkOutput("after_reset_done_count", done_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_result_streamer.md
Name: fir_result_streamer

Overview:
- Reads a completed FIR output region back out of the shared dual-port sample memory over port B.
- Streams the samples as a valid/ready byte stream, e.g. toward a UART or logic-analyzer capture path.
- Reader counterpart to the FIR engine, which writes results into memory at output_addr.
- Replaces the bench-only practice of peeking at memory contents hierarchically.

Parameters:
- ADDR_W, 10, memory address width; address arithmetic wraps modulo 2^ADDR_W.
- DATA_W, 8, sample width, signed two's complement, passed through unmodified.
- FIFO_DEPTH, 2, internal prefetch buffer entries; must be at least 2 for full throughput.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-low reset; rst=0 clears all state immediately.
- start  in  1  level-sampled; a rising-edge-free sample of 1 while IDLE launches a transfer.
- base_addr  in  ADDR_W  first address to read; captured when start is accepted.
- count  in  ADDR_W  number of samples to stream; captured when start is accepted.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when the final beat is accepted.
- mem_en_b  out  1  port-B read enable.
- mem_addr_b  out  ADDR_W  port-B read address.
- mem_data_b  in  DATA_W  port-B read data, valid exactly 1 cycle after mem_en_b.
- m_valid  out  1  output stream valid.
- m_ready  in  1  output stream ready.
- m_data  out  DATA_W  output sample.
- m_last  out  1  high with the final beat of a transfer.

Behaviour:
- Reset values: busy=0, done=0, mem_en_b=0, mem_addr_b=0, m_valid=0, m_data=0, m_last=0. FSM=IDLE, FIFO empty, counters 0.
- FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE: on start=1 at a clock edge, capture base_addr and count, then:
  - count=0: go to FINISH (no reads, no beats).
  - otherwise: go to READ with busy=1.
- READ: issue one read per cycle while (fifo_occupancy + inflight) < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - mem_addr_b = base + issued_count, modulo 2^ADDR_W (0x3FF wraps to 0x000).
  - After count reads have been issued, go to DRAIN.
- DRAIN: no further reads. When the beat with m_last is accepted (m_valid & m_ready), go to FINISH.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
- Latency: start sampled at edge T → first mem_en_b during cycle T+1 → data captured into the FIFO at edge T+2 → m_valid=1 from cycle T+2 onward (registered FIFO head).
- Throughput: 1 beat/cycle with m_ready held high.
- Handshake rules:
  - A beat transfers when m_valid & m_ready at an edge.
  - While m_valid=1 and m_ready=0, m_data and m_last hold stable and m_valid stays high.
  - m_valid never depends combinationally on m_ready.
  - No read is ever issued that could overflow the FIFO; no sample is dropped or duplicated.
- m_last is high only on beat index count-1.
- start while busy is ignored; captured parameters do not change mid-transfer.
- Reset mid-operation: all state clears asynchronously. Any in-flight read data returning after reset deassertion is discarded, because the FIFO write is gated by a registered inflight flag that is also cleared.
- Width rules:
  - count is unsigned; maximum count is 2^ADDR_W-1 = 1023.
  - Internal counters are ADDR_W+1 bits wide so that issued == count compares correctly at 1023.

Decomposition:
- Shared package fir_pkg holds:
  - ADDR_W, DATA_W
  - FSM state enum (ST_IDLE, ST_READ, ST_DRAIN, ST_FINISH)
  - default output base constant OUT_BASE = 10'd256.
- One sub-module, stream_fifo: a small synchronous FIFO (DEPTH, WIDTH) with push, pop, head, count, full and empty outputs, and registered head data.

Test Plan:
- Basic transfer: memory preloaded 256..275 = 0..19, base=256, count=20, m_ready=1.
  - Required: 20 beats with data 0..19 on consecutive cycles.
  - First m_valid 2 cycles after the start edge; m_last only on the beat with data 19.
  - done pulses once, one cycle after that beat; busy is low afterwards.
- Backpressure: same setup, m_ready toggling 1,0,0,1 repeating.
  - Required: identical 20-value sequence.
  - m_data stable during every stall; mem_en_b never pushes the FIFO past 2 entries; no loss or duplication.
- Wrap-around: base=1020, count=8, mem[1020..1023]=-4..-1 and mem[0..3]=1..4.
  - Required: beats -4,-3,-2,-1,1,2,3,4, with mem_addr_b sequence 1020..1023,0..3.
- Zero count: start with count=0.
  - Required: no mem_en_b, no m_valid, done pulses exactly once, busy high for at most one cycle.
- Mid-transfer reset and ignored start:
  - Assert start again during a count=20 transfer. Required: ignored, transfer unchanged.
  - Drop rst for 1 cycle after 5 beats. Required: all outputs return to reset values immediately and no stale beat appears.
  - A new transfer with base=256, count=3 then yields exactly 0,1,2.
